// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into STAGES ripple slices, one per stage,
// with a single global enable that stalls every stage when the output is held.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CHUNK = WIDTH / STAGES;
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    for (genvar s = 0; s < STAGES; s++) begin : g_st
        // Operands arrive shifted so the slice to add is always the low CHUNK bits.
        localparam int RW = WIDTH - s * CHUNK;
        logic [RW-1:0] a_i, b_i;
        logic c_i, v_i, co, ld;
        logic [CHUNK-1:0] part;
        logic v_d, v_q, c_d, c_q;
        logic [(s+1)*CHUNK-1:0] r_d, r_q;
        if (s == 0) begin : g_in
            assign a_i = A;
            assign b_i = sub ? ~B : B;
            assign c_i = sub | cin;
            assign v_i = in_valid;
            always_comb r_d = ld ? part : r_q;
        end else begin : g_mid
            assign a_i = g_st[s-1].g_pass.a_q;
            assign b_i = g_st[s-1].g_pass.b_q;
            assign c_i = g_st[s-1].c_q;
            assign v_i = g_st[s-1].v_q;
            always_comb r_d = ld ? {part, g_st[s-1].r_q} : r_q;
        end
        always_comb begin
            ld        = en && v_i;
            {co, part} = {1'b0, a_i[CHUNK-1:0]} + {1'b0, b_i[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_i};
            v_d       = en ? v_i : v_q;
            c_d       = ld ? co : c_q;
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                r_q <= '0;
            end else begin
                v_q <= v_d;
                c_q <= c_d;
                r_q <= r_d;
            end
        end
        if (s < STAGES - 1) begin : g_pass
            logic [RW-CHUNK-1:0] a_d, a_q, b_d, b_q;
            always_comb begin
                a_d = ld ? a_i[RW-1:CHUNK] : a_q;
                b_d = ld ? b_i[RW-1:CHUNK] : b_q;
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end else begin : g_last
            // Carry into the MSB recovered as a ^ b ^ sum at that bit.
            logic ovf_d, ovf_q;
            always_comb ovf_d = ld ? (a_i[RW-1] ^ b_i[RW-1] ^ part[CHUNK-1] ^ co) : ovf_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) ovf_q <= 1'b0;
                else     ovf_q <= ovf_d;
            end
        end
    end
    assign out_valid = g_st[STAGES-1].v_q;
    assign sum       = g_st[STAGES-1].r_q;
    assign cout      = g_st[STAGES-1].c_q;
    assign ovf       = g_st[STAGES-1].g_last.ovf_q;
endmodule
